// File: rtl/req_rr_scheduler_if.sv
// Request/grant bundle between N requesters and the round-robin scheduler.
// The master side drives requests; the slave side (scheduler) returns grants.
interface req_rr_scheduler_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           expire;

    modport master (output req, input gnt, gnt_id, busy, expire);
    modport slave  (input req, output gnt, gnt_id, busy, expire);
endinterface

// File: rtl/req_rr_scheduler.sv
// Round-robin scheduler with capped grant tenure and registered one-hot grant.
// Define REQ_RR_SCHED_ASSERT_EN to compile in latency/one-hot assertions and covers.
module req_rr_scheduler #(
    parameter int unsigned N        = 3,
    parameter int unsigned MAX_HOLD = 2
) (
    input  logic             clk,
    input  logic             rst,
    req_rr_scheduler_if.slave bus
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] RR_RESET  = IDW'(N - 1);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_q,    rr_d;
    logic [HW-1:0]  hcnt_q,  hcnt_d;
    logic [N-1:0]   gnt_q,   gnt_d;
    logic           busy_q,  busy_d;
    logic           expire_q, expire_d;

    logic [N-1:0]   others;
    logic           any_found, oth_found;
    logic [IDW-1:0] any_idx,   oth_idx;
    logic           take;
    logic [IDW-1:0] take_idx;

    // First set bit scanning from+1, from+2, ... modulo N; 'from' itself is last.
    function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] from);
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDW'((32'(from) + k) % N);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign others                 = bus.req & ~(N'(1) << owner_q);
    assign {any_found, any_idx}   = pick(bus.req, rr_q);
    assign {oth_found, oth_idx}   = pick(others, rr_q);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_q     <= RR_RESET;
            hcnt_q   <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            hcnt_q   <= hcnt_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            expire_q <= expire_d;
        end
    end

    // Next-owner decision; in OWN, rr equals the owner so it is scanned last.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        hcnt_d   = hcnt_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        expire_d = 1'b0;
        take     = 1'b0;
        take_idx = '0;

        case (state_q)
            IDLE: begin
                if (any_found) begin
                    take     = 1'b1;
                    take_idx = any_idx;
                end
            end
            OWN: begin
                if (!bus.req[owner_q]) begin
                    if (oth_found) begin
                        take     = 1'b1;
                        take_idx = oth_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        hcnt_d  = '0;
                    end
                end else if (oth_found && (hcnt_q == HOLD_LAST)) begin
                    take     = 1'b1;
                    take_idx = oth_idx;
                    expire_d = 1'b1;
                end else if (hcnt_q != HOLD_LAST) begin
                    hcnt_d = HW'(hcnt_q + 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (take) begin
            state_d = OWN;
            owner_d = take_idx;
            rr_d    = take_idx;
            hcnt_d  = '0;
            gnt_d   = N'(1) << take_idx;
            busy_d  = 1'b1;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = owner_q;
    assign bus.busy   = busy_q;
    assign bus.expire = expire_q;

`ifdef REQ_RR_SCHED_ASSERT_EN
    localparam int unsigned WAIT_BOUND = (N - 1) * MAX_HOLD + 1;

    default clocking cb @(posedge clk);
    endclocking
    default disable iff (rst);

    for (genvar i = 0; i < int'(N); i++) begin : g_chk
        a_latency: assert property ($rose(bus.req[i]) |-> ##[1:WAIT_BOUND] bus.gnt[i]);
        a_req_ok:  assert property (bus.gnt[i] |-> $past(bus.req[i]));
    end

    a_onehot:  assert property ($onehot0(bus.gnt));
    c_expire:  cover property (bus.expire);
    c_handoff: cover property (busy_q && $past(busy_q) && (gnt_q != $past(gnt_q)));
`endif
endmodule

// File: tb/tb_req_rr_scheduler.sv
// Directed and randomised bench for req_rr_scheduler against a queue-free
// behavioural owner/tenure model derived from the scheduling rules.
module tb_req_rr_scheduler;
    localparam int N        = 3;
    localparam int MAX_HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    req_rr_scheduler_if #(.N(N)) bus ();

    req_rr_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 idle), last owner, cycles held so far.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_held  = 0;
    bit m_exp   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int find(input logic [N-1:0] r, input int after, input int excl);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (after + k) % N;
            if (idx != excl && r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;
        m_exp   = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int w;
        m_exp = 1'b0;
        if (m_owner < 0) begin
            w = find(r, m_last, -1);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_held = 1;
            end
        end else begin
            w = find(r, m_last, m_owner);
            if (!r[m_owner]) begin
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_held = 1;
                end else begin
                    m_owner = -1;
                end
            end else if (w >= 0 && m_held >= MAX_HOLD) begin
                m_owner = w; m_last = w; m_held = 1; m_exp = 1'b1;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk({tag, ".gnt"},    32'(bus.gnt),    32'(eg));
        chk({tag, ".busy"},   32'(bus.busy),   32'(m_owner >= 0));
        chk({tag, ".expire"}, 32'(bus.expire), 32'(m_exp));
        if (m_owner >= 0) begin
            chk({tag, ".gnt_id"}, 32'(bus.gnt_id),   32'(m_owner));
            chk({tag, ".hcnt"},   32'(dut.hcnt_q),   32'(m_held - 1));
        end
    endtask

    // Drive req away from the edge, let one edge pass, then compare.
    task automatic apply(input logic [N-1:0] r, input string tag);
        bus.req = r;
        @(posedge clk);
        #1;
        model_step(r);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] seq_gnt [7];
        logic         seq_exp [7];
        seq_gnt = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        seq_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        bus.req = '0;
        do_reset();
        chk("reset.gnt",    32'(bus.gnt),    32'h0);
        chk("reset.gnt_id", 32'(bus.gnt_id), 32'h0);
        chk("reset.busy",   32'(bus.busy),   32'h0);
        chk("reset.expire", 32'(bus.expire), 32'h0);

        // Single requester, one-cycle grant latency, release to idle.
        apply(3'b010, "single1");
        chk("single1.const", 32'(bus.gnt), 32'h2);
        apply(3'b010, "single2");
        apply(3'b010, "single3");
        apply(3'b000, "single_drop");
        chk("single_drop.const", 32'(bus.gnt), 32'h0);

        // All requesting: tenure capped at MAX_HOLD, rotation from requester 0.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(3'b111, "all");
            chk("all.seq_gnt", 32'(bus.gnt),    32'(seq_gnt[i]));
            chk("all.seq_exp", 32'(bus.expire), 32'(seq_exp[i]));
        end

        // Sole requester keeps the grant, hold counter saturates.
        apply(3'b000, "idle");
        for (int i = 0; i < 10; i++) begin
            apply(3'b001, "sole");
            chk("sole.gnt", 32'(bus.gnt), 32'h1);
        end
        chk("sole.hcnt_sat", 32'(dut.hcnt_q), 32'(MAX_HOLD - 1));

        // Owner 1 releases with 0 and 2 pending: back-to-back handoff to 2.
        apply(3'b010, "to1");
        chk("to1.gnt", 32'(bus.gnt), 32'h2);
        apply(3'b101, "drop1");
        chk("drop1.gnt",  32'(bus.gnt),  32'h4);
        chk("drop1.busy", 32'(bus.busy), 32'h1);

        // Asynchronous reset mid-tenure.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.gnt",  32'(bus.gnt),  32'h0);
        chk("async_rst.busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        apply(3'b101, "post_rst");
        chk("post_rst.gnt", 32'(bus.gnt), 32'h1);

        // Randomised level requests with random toggling.
        r = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            apply(r, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
